// File: rtl/fft_frame_ctrl.sv
// fft_frame_ctrl: buffers 16 serial samples, launches them into the FFT stage chain and drains the result
module fft_frame_ctrl #(
  parameter int DP_LATENCY = 4,
  parameter int BITREV = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [15:0]  in_data,
  output logic         in_ready,
  output logic [511:0] dp_frame,
  output logic         dp_start,
  input  logic [511:0] dp_result,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [15:0]  out_real,
  output logic [15:0]  out_imag,
  output logic [3:0]   out_index,
  output logic         frame_done,
  output logic         busy
);
  typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;
  localparam logic [3:0] LAT = 4'(DP_LATENCY);
  state_t state_q, state_d;
  logic [255:0] ibuf_q, ibuf_d, frame_q, frame_d;
  logic [511:0] obuf_q, obuf_d;
  logic [3:0] cnt_in_q, cnt_in_d, wait_cnt_q, wait_cnt_d, k_q, k_d;
  logic ibuf_full_q, ibuf_full_d, dp_start_q, dp_start_d, frame_done_q, frame_done_d;
  logic accept, launch, last_hs;
  logic [3:0] rd_idx;
  logic [31:0] rd_word;
  // input buffer fills independently of the frame FSM; launch frees it
  always_comb begin
    accept = in_valid & ~ibuf_full_q;
    ibuf_d = ibuf_q;
    if (accept) ibuf_d[{cnt_in_q, 4'b0000} +: 16] = in_data;
    cnt_in_d = accept ? cnt_in_q + 4'd1 : cnt_in_q;
    ibuf_full_d = (accept && cnt_in_q == 4'd15) ? 1'b1 : launch ? 1'b0 : ibuf_full_q;
  end
  // frame sequencing: launch a full buffer, wait out the chain latency, drain bins
  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    obuf_d = obuf_q;
    wait_cnt_d = wait_cnt_q;
    k_d = k_q;
    launch = 1'b0;
    last_hs = 1'b0;
    case (state_q)
      IDLE: if (ibuf_full_q) begin
        launch = 1'b1;
        frame_d = ibuf_q;
        wait_cnt_d = LAT;
        state_d = WAIT;
      end
      WAIT: if (wait_cnt_q == 4'd0) begin
        obuf_d = dp_result;
        k_d = 4'd0;
        state_d = DRAIN;
      end else begin
        wait_cnt_d = wait_cnt_q - 4'd1;
      end
      DRAIN: if (out_ready) begin
        k_d = k_q + 4'd1;
        last_hs = k_q == 4'd15;
        state_d = k_q == 4'd15 ? IDLE : DRAIN;
      end
      default: state_d = IDLE;
    endcase
    dp_start_d = launch;
    frame_done_d = last_hs;
  end
  // output word selection; outputs are zero outside DRAIN
  always_comb begin
    rd_idx = BITREV != 0 ? {k_q[0], k_q[1], k_q[2], k_q[3]} : k_q;
    rd_word = obuf_q[{rd_idx, 5'b00000} +: 32];
    out_valid = state_q == DRAIN;
    out_index = out_valid ? k_q : 4'd0;
    out_real = out_valid ? rd_word[31:16] : 16'd0;
    out_imag = out_valid ? rd_word[15:0] : 16'd0;
    in_ready = ~ibuf_full_q;
    busy = state_q != IDLE;
    dp_start = dp_start_q;
    frame_done = frame_done_q;
  end
  for (genvar i = 0; i < 16; i++) begin : g_frame
    assign dp_frame[32*i +: 32] = {frame_q[16*i +: 16], 16'h0000};
  end
  // state registers; reset discards any partial or in-flight frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ibuf_q <= '0;
      frame_q <= '0;
      obuf_q <= '0;
      cnt_in_q <= '0;
      wait_cnt_q <= '0;
      k_q <= '0;
      ibuf_full_q <= 1'b0;
      dp_start_q <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ibuf_q <= ibuf_d;
      frame_q <= frame_d;
      obuf_q <= obuf_d;
      cnt_in_q <= cnt_in_d;
      wait_cnt_q <= wait_cnt_d;
      k_q <= k_d;
      ibuf_full_q <= ibuf_full_d;
      dp_start_q <= dp_start_d;
      frame_done_q <= frame_done_d;
    end
  end
endmodule

// File: tb/tb_fft_frame_ctrl.sv
// tb_fft_frame_ctrl: directed and randomized checks of fft_frame_ctrl against a frame-level model
module tb_fft_frame_ctrl;
  logic clk = 1'b0;
  logic rst[3], in_valid[3], in_ready[3], dp_start[3], out_valid[3], out_ready[3], frame_done[3], busy[3];
  logic [15:0] in_data[3], out_real[3], out_imag[3];
  logic [3:0] out_index[3];
  logic [511:0] dp_frame[3], dp_result[3];
  always #5 clk = ~clk;
  // instance 0: defaults, instance 1: BITREV=0/latency 0, instance 2: latency 10
  for (genvar g = 0; g < 3; g++) begin : gi
    localparam int LG = g == 0 ? 4 : g == 1 ? 0 : 10;
    localparam int BG = g == 1 ? 0 : 1;
    int age;
    logic [511:0] res;
    fft_frame_ctrl #(.DP_LATENCY(LG), .BITREV(BG)) u_dut (
      .clk(clk), .rst(rst[g]), .in_valid(in_valid[g]), .in_data(in_data[g]), .in_ready(in_ready[g]),
      .dp_frame(dp_frame[g]), .dp_start(dp_start[g]), .dp_result(dp_result[g]),
      .out_valid(out_valid[g]), .out_ready(out_ready[g]), .out_real(out_real[g]), .out_imag(out_imag[g]),
      .out_index(out_index[g]), .frame_done(frame_done[g]), .busy(busy[g]));
    // stub chain: cycles elapsed since dp_start
    always @(posedge clk or posedge rst[g]) begin
      if (rst[g]) age <= 15;
      else age <= dp_start[g] ? 1 : (age < 15 ? age + 1 : 15);
    end
    // stub result is only correct in the cycle that must be captured; corrupted otherwise
    always_comb begin
      res = '0;
      for (int j = 0; j < 16; j++) res[32*j +: 32] = {dp_frame[g][32*j+16 +: 16] + 16'(j), 16'hA000 + 16'(j)};
      if ((dp_start[g] ? 0 : age) != LG) res = ~res;
    end
    assign dp_result[g] = res;
  end

  int n_chk, n_fail, cyc, mode, act, bin, nstart, first_start, first_ov, fd_cyc, ndone, nhs;
  logic fd_exp;
  logic [15:0] acc[$];
  logic [15:0] frames[$];
  logic [15:0] got_real[16], got_imag[16];

  function automatic int brev(input int k);
    int r = 0;
    for (int i = 0; i < 4; i++) r = r * 2 + ((k >> i) & 1);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_model();
    acc.delete();
    frames.delete();
    bin = 0;
    fd_exp = 1'b0;
  endtask

  task automatic track_reset();
    cyc = 0;
    nstart = 0;
    first_start = -1;
    first_ov = -1;
    fd_cyc = -1;
  endtask

  // one cycle of the active instance: drive out_ready, check outputs against the model, advance
  task automatic step();
    int w;
    out_ready[act] = mode == 0 ? 1'b0 : mode == 1 ? 1'b1 : mode == 2 ? 1'(cyc % 2 == 0) : 1'($urandom_range(0, 1));
    chk("frame_done", 32'(frame_done[act]), 32'(fd_exp));
    if (frame_done[act] && fd_cyc < 0) fd_cyc = cyc;
    fd_exp = 1'b0;
    if (dp_start[act]) begin
      nstart++;
      if (first_start < 0) first_start = cyc;
      chk("launch_avail", 32'(frames.size() >= 16), 32'd1);
      if (frames.size() >= 16)
        for (int j = 0; j < 16; j++) chk("dp_frame", dp_frame[act][32*j +: 32], {frames[j], 16'h0000});
    end
    if (out_valid[act]) begin
      if (first_ov < 0) first_ov = cyc;
      chk("drain_avail", 32'(frames.size() >= 16), 32'd1);
      if (frames.size() >= 16) begin
        w = act != 1 ? brev(bin) : bin;
        chk("out_index", 32'(out_index[act]), 32'(bin));
        chk("out_real", 32'(out_real[act]), 32'(frames[w] + 16'(w)));
        chk("out_imag", 32'(out_imag[act]), 32'(16'hA000 + 16'(w)));
      end
      if (out_ready[act]) begin
        got_real[bin] = out_real[act];
        got_imag[bin] = out_imag[act];
        nhs++;
        bin++;
        if (bin == 16) begin
          bin = 0;
          ndone++;
          fd_exp = 1'b1;
          repeat (16) if (frames.size() > 0) void'(frames.pop_front());
        end
      end
    end
    if (in_valid[act] && in_ready[act]) begin
      acc.push_back(in_data[act]);
      if (acc.size() == 16) begin
        foreach (acc[i]) frames.push_back(acc[i]);
        acc.delete();
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic send(input logic [15:0] d);
    int t = 0;
    in_valid[act] = 1'b1;
    in_data[act] = d;
    while (!in_ready[act] && t < 300) begin
      step();
      t++;
    end
    chk("send_timeout", 32'(t < 300), 32'd1);
    step();
    in_valid[act] = 1'b0;
  endtask

  initial begin
    int n0, h0, s0;
    for (int g = 0; g < 3; g++) begin
      rst[g] = 1'b1;
      in_valid[g] = 1'b0;
      in_data[g] = '0;
      out_ready[g] = 1'b0;
    end
    n_chk = 0; n_fail = 0; ndone = 0; nhs = 0; act = 0; mode = 1;
    clear_model();
    track_reset();
    @(negedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready[0]), 32'd1);
    chk("rst_out_valid", 32'(out_valid[0]), 32'd0);
    chk("rst_busy", 32'(busy[0]), 32'd0);
    chk("rst_dp_start", 32'(dp_start[0]), 32'd0);
    chk("rst_frame_done", 32'(frame_done[0]), 32'd0);
    chk("rst_out_word", {out_real[0], out_imag[0]}, 32'd0);
    chk("rst_out_index", 32'(out_index[0]), 32'd0);
    chk("rst_dp_frame", 32'(|dp_frame[0]), 32'd0);
    for (int g = 0; g < 3; g++) rst[g] = 1'b0;
    @(negedge clk);
    // ramp frame, back-to-back, sink always ready
    track_reset();
    for (int n = 0; n < 16; n++) send(16'(n * 16));
    for (int t = 0; t < 100 && fd_cyc < 0; t++) step();
    chk("start_cycle", first_start, 32'd17);
    chk("start_count", nstart, 32'd1);
    chk("first_valid_cycle", first_ov, 32'd22);
    chk("frame_done_cycle", fd_cyc, 32'd38);
    chk("bin1_real", 32'(got_real[1]), 32'h0088);
    chk("bin1_imag", 32'(got_imag[1]), 32'hA008);
    chk("bin0_real", 32'(got_real[0]), 32'h0000);
    chk("bin0_imag", 32'(got_imag[0]), 32'hA000);
    chk("bin15_real", 32'(got_real[15]), 32'h00FF);
    chk("bin15_imag", 32'(got_imag[15]), 32'hA00F);
    // backpressure: out_ready toggles every cycle
    track_reset(); mode = 2; n0 = ndone; h0 = nhs;
    for (int n = 0; n < 16; n++) send(16'($urandom));
    for (int t = 0; t < 300 && ndone == n0; t++) step();
    chk("bp_frames", ndone - n0, 32'd1);
    chk("bp_bins", nhs - h0, 32'd16);
    // overlap: second frame buffered while first is stalled in drain
    track_reset(); mode = 0; n0 = ndone;
    for (int n = 0; n < 16; n++) send(16'($urandom));
    for (int t = 0; t < 50 && !out_valid[0]; t++) step();
    chk("ov_stalled", 32'(out_valid[0]), 32'd1);
    s0 = nstart;
    for (int n = 0; n < 16; n++) send(16'($urandom));
    in_valid[0] = 1'b1;
    in_data[0] = 16'h1234;
    repeat (5) step();
    chk("full_in_ready", 32'(in_ready[0]), 32'd0);
    in_valid[0] = 1'b0;
    repeat (3) step();
    chk("no_start_stalled", nstart - s0, 32'd0);
    chk("still_draining", 32'(out_valid[0]), 32'd1);
    mode = 1; fd_cyc = -1; first_start = -1;
    for (int t = 0; t < 100 && fd_cyc < 0; t++) step();
    for (int t = 0; t < 20 && first_start < 0; t++) step();
    chk("relaunch_gap", first_start - fd_cyc, 32'd1);
    for (int t = 0; t < 200 && ndone < n0 + 2; t++) step();
    chk("overlap_frames", ndone - n0, 32'd2);
    // reset in WAIT with 7 next-frame samples buffered (latency 10 instance)
    act = 2; clear_model(); track_reset(); mode = 1;
    for (int n = 0; n < 23; n++) send(16'($urandom));
    chk("wait_busy", 32'(busy[2]), 32'd1);
    chk("wait_no_valid", 32'(out_valid[2]), 32'd0);
    rst[2] = 1'b1;
    #1;
    chk("async_rst_valid", 32'(out_valid[2]), 32'd0);
    chk("async_rst_busy", 32'(busy[2]), 32'd0);
    chk("async_rst_ready", 32'(in_ready[2]), 32'd1);
    chk("async_rst_start", 32'(dp_start[2]), 32'd0);
    @(negedge clk);
    rst[2] = 1'b0;
    clear_model(); n0 = ndone; mode = 3;
    @(negedge clk);
    for (int n = 0; n < 16; n++) send(16'($urandom));
    for (int t = 0; t < 400 && ndone == n0; t++) step();
    chk("post_rst_frame", ndone - n0, 32'd1);
    // BITREV=0, latency 0
    act = 1; clear_model(); track_reset(); mode = 1;
    for (int n = 0; n < 16; n++) send(16'($urandom));
    for (int t = 0; t < 100 && fd_cyc < 0; t++) step();
    chk("l0_start_cycle", first_start, 32'd17);
    chk("l0_first_valid", first_ov, 32'd18);
    chk("l0_done_cycle", fd_cyc, 32'd34);
    // randomized traffic on the default instance
    act = 0; clear_model(); track_reset(); mode = 3; n0 = ndone;
    for (int n = 0; n < 48; n++) begin
      if ($urandom_range(0, 3) == 0) step();
      send(16'($urandom));
    end
    for (int t = 0; t < 2000 && ndone < n0 + 3; t++) step();
    chk("rand_frames", ndone - n0, 32'd3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fft_frame_ctrl.md
Name: fft_frame_ctrl

Overview:
- Sequences the 16-point radix-2 FFT datapath: collects a serial stream of 16 real samples, launches one frame into the combinational/pipelined stage chain, captures the result after a fixed latency, and drains it serially in natural order.
- The input buffer refills while the previous frame is computing and draining.
- Sits between the FIR/sample source and the FFT output interface; owns the stage chain's frame bus.

Parameters:
- DP_LATENCY, 4, cycles from the dp_start-high cycle to the cycle whose ending edge captures dp_result (0 = purely combinational chain, legal range 0..15).
- BITREV, 1, 1 = output index k reads result word bitrev4(k); 0 = reads word k.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  sample valid
- in_data  in  16  signed real sample, same fixed-point format as the datapath real field
- in_ready  out  1  controller can accept a sample
- dp_frame  out  512  word i at [32i+31:32i] = {sample i, 16'h0000}
- dp_start  out  1  one-cycle pulse marking a new frame on dp_frame
- dp_result  in  512  stage-chain output, word j = {real[31:16], imag[15:0]}
- out_valid  out  1  output word valid
- out_ready  in  1  sink accepts output word
- out_real  out  16  real part of X[out_index]
- out_imag  out  16  imaginary part of X[out_index]
- out_index  out  4  frequency bin k
- frame_done  out  1  one-cycle pulse after the last bin of a frame is accepted
- busy  out  1  state != IDLE

Behaviour:
- Reset (async, immediate): all outputs 0 except in_ready = 1. Counters are 0, ibuf_full = 0, state = IDLE, and any partial or in-flight frame is discarded.
- Input side (independent of the FSM):
  - in_ready = ~ibuf_full (direct from register).
  - On in_valid & in_ready: ibuf[cnt_in] <= in_data and cnt_in increments.
  - Accepting sample 15 sets ibuf_full and wraps cnt_in to 0.
  - in_valid while in_ready = 0 is ignored; the sample is not lost, because the source holds it.
- FSM states: IDLE, WAIT, DRAIN.
  - IDLE: if ibuf_full, at the edge do: dp_frame <= ibuf, dp_start <= 1, wait_cnt <= DP_LATENCY, ibuf_full <= 0, go to WAIT. in_ready rises in the next cycle.
  - WAIT: dp_start is high only in the first WAIT cycle, and dp_frame is held stable throughout. At the edge ending the cycle in which wait_cnt == 0: obuf <= dp_result, k <= 0, go to DRAIN. Otherwise wait_cnt decrements.
  - DRAIN: out_valid = 1, out_index = k, {out_real, out_imag} = obuf[BITREV ? bitrev4(k) : k].
    - On out_valid & out_ready: k increments.
    - On the handshake with k == 15: go to IDLE, and frame_done is high in the following cycle.
    - While out_ready = 0, all out_* remain stable.
- Timing: with a back-to-back stream, the 16th sample is accepted in cycle 15.
  - ibuf_full is visible in cycle 16; dp_start is high in cycle 17.
  - out_valid first rises in cycle 18+DP_LATENCY (22 by default).
- Simultaneous events:
  - Final DRAIN handshake while ibuf_full = 1: go to IDLE, and the launch occurs at the next edge (one IDLE cycle).
  - The 16th input accept in the same cycle as a WAIT→DRAIN capture is independent; both proceed.
  - The input side keeps accepting during WAIT and DRAIN until ibuf_full.
- Widths: no arithmetic on data, pass-through only. dp_frame imag halves are always 16'h0000.

Test Plan:
- Reset then stream x[n] = n*16'h0010 (n = 0..15) into a stub datapath. The stub returns word j = {frame_real_j + j, 16'hA000 + j}, delayed by DP_LATENCY.
  - Required: out_index 1 gives out_real = 16'h0088 and out_imag = 16'hA008.
  - Required: bin 0 gives 16'h0000 / 16'hA000, and bin 15 gives 16'h00FF / 16'hA00F.
- Timing: back-to-back input with DP_LATENCY = 4 → dp_start high only in cycle 17, out_valid rises in cycle 22, and frame_done pulses the cycle after the 16th accepted bin.
- Backpressure: toggle out_ready 1010... during DRAIN → outputs stay stable while stalled, 16 bins arrive in order 0..15, and there are no duplicates or skips.
- Overlap: stream frame 2 during frame 1's DRAIN while holding out_ready = 0.
  - Required: in_ready drops after 16 samples and dp_start does not fire.
  - Required: releasing out_ready completes frame 1, then launches frame 2 after one IDLE cycle.
- Reset mid-op: assert rst during WAIT with 7 frame-2 samples buffered → immediately out_valid = 0, busy = 0, in_ready = 1; a fresh 16 samples produce a correct frame.
- BITREV = 0, DP_LATENCY = 0 → bin k returns stub word k, and out_valid rises in cycle 18.
